// File: rtl/soc_irq_pkg.sv
// Shared types and limits for the SoC interrupt arbiter.
package soc_irq_pkg;

    localparam int IRQ_ID_WIDTH    = 4;
    localparam int IRQ_MAX_SOURCES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/soc_irq_arbiter_if.sv
// CPU-side interrupt handshake: offer (valid/id), accept (ack), completion (done).
interface soc_irq_arbiter_if;
    import soc_irq_pkg::*;

    logic                    irq_valid;
    logic [IRQ_ID_WIDTH-1:0] irq_id;
    logic                    irq_ack;
    logic                    irq_done;
    logic                    in_service;

    modport master (
        output irq_valid, irq_id, in_service,
        input  irq_ack, irq_done
    );

    modport slave (
        input  irq_valid, irq_id, in_service,
        output irq_ack, irq_done
    );

endinterface

// File: rtl/soc_irq_rr_picker.sv
// Combinational rotate-priority search: first set bit of eligible at or after start, with wrap.
module soc_irq_rr_picker
    import soc_irq_pkg::*;
#(
    parameter int SOURCE_COUNT = 8
) (
    input  logic [SOURCE_COUNT-1:0] eligible,
    input  logic [IRQ_ID_WIDTH-1:0] start,
    output logic                    found,
    output logic [IRQ_ID_WIDTH-1:0] index
);

    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        index = '0;
        for (int i = 0; i < SOURCE_COUNT; i++) begin
            cand = (int'(start) + i) % SOURCE_COUNT;
            if (!found && eligible[cand]) begin
                found = 1'b1;
                index = IRQ_ID_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/soc_irq_arbiter.sv
// Interrupt arbiter: sticky per-source pending bits, masked selection, and a
// single offer/service handshake towards the CPU.
module soc_irq_arbiter
    import soc_irq_pkg::*;
#(
    parameter int SOURCE_COUNT = 8,
    parameter int ROUND_ROBIN  = 1
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic [SOURCE_COUNT-1:0] irq_pulse,
    input  logic [SOURCE_COUNT-1:0] irq_enable,
    output logic [SOURCE_COUNT-1:0] pending,
    soc_irq_arbiter_if.master       cpu
);

    if (SOURCE_COUNT < 1 || SOURCE_COUNT > IRQ_MAX_SOURCES) begin : g_bad_count
        $error("soc_irq_arbiter: SOURCE_COUNT must be 1..%0d", IRQ_MAX_SOURCES);
    end

    irq_state_t              state;
    logic [IRQ_ID_WIDTH-1:0] rr_ptr;
    logic [IRQ_ID_WIDTH-1:0] rr_next;
    logic [IRQ_ID_WIDTH-1:0] pick_start;
    logic [IRQ_ID_WIDTH-1:0] pick_index;
    logic                    pick_found;
    logic                    ack_take;
    logic [SOURCE_COUNT-1:0] clr_mask;
    logic [SOURCE_COUNT-1:0] eligible;

    assign eligible   = pending & irq_enable;
    assign ack_take   = (state == OFFER) && cpu.irq_ack;
    assign pick_start = (ROUND_ROBIN != 0) ? rr_ptr : '0;
    assign rr_next    = (cpu.irq_id == IRQ_ID_WIDTH'(SOURCE_COUNT - 1)) ? '0 : cpu.irq_id + 1'b1;

    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < SOURCE_COUNT; k++) begin
            clr_mask[k] = ack_take && (cpu.irq_id == IRQ_ID_WIDTH'(k));
        end
    end

    soc_irq_rr_picker #(
        .SOURCE_COUNT(SOURCE_COUNT)
    ) u_picker (
        .eligible(eligible),
        .start   (pick_start),
        .found   (pick_found),
        .index   (pick_index)
    );

    // A new pulse wins over the clear of an accepted ack on the same source.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | irq_pulse;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state          <= IDLE;
            cpu.irq_valid  <= 1'b0;
            cpu.irq_id     <= '0;
            cpu.in_service <= 1'b0;
            rr_ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        cpu.irq_id    <= pick_index;
                        cpu.irq_valid <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    // Done in the same cycle as ack is dropped: the handler has not started yet.
                    if (cpu.irq_ack) begin
                        cpu.irq_valid  <= 1'b0;
                        cpu.in_service <= 1'b1;
                        state          <= SERVICE;
                        if (ROUND_ROBIN != 0) begin
                            rr_ptr <= rr_next;
                        end
                    end
                end
                SERVICE: begin
                    if (cpu.irq_done) begin
                        cpu.in_service <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    cpu.irq_valid  <= 1'b0;
                    cpu.in_service <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule
